frv_mask_rng: RTL and testbench

Randomness source for the masked-ALU datapath. It feeds fresh 32-bit mask words to the boolean-masking functional unit, which forms the two-share result `{rs1 ^ mask, mask}`. It also exports the consumed word as `rvfi_mask_data` so the formal instruction models can recompute both shares. The block holds a 32-bit Galois LFSR, a small prefetch FIFO, and a reseed port driven by the CSR block.

---
 rtl/frv_mask_rng.sv | 145 ++++++++++++++
 tb/tb_frv_mask_rng.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/frv_mask_rng.sv
`default_nettype none
// ============================================================================
// Module   : frv_mask_rng
// Purpose  : Galois-LFSR mask source with an optional prefetch FIFO and a
//            CSR reseed port. FRV_MASK_RNG_FIFO_EN selects the FIFO build.
// Revision : 1.0 - initial release
// ============================================================================
module frv_mask_rng #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic                     g_clk,
  input  logic                     g_rst,
  input  logic                     seed_valid,
  input  logic [31:0]              seed_data,
  output logic                     seed_ready,
  output logic                     mask_valid,
  input  logic                     mask_ready,
  output logic [31:0]              mask_data,
  output logic [31:0]              rvfi_mask_data,
  output logic [$clog2(DEPTH):0]   rng_level
);

  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] C_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ C_TAPS) : (s >> 1);
  endfunction

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] rvfi_q;
  logic [31:0] w_seed_mix;
  logic        w_pop;

  assign seed_ready     = 1'b1;
  assign rvfi_mask_data = rvfi_q;
  assign w_seed_mix     = lfsr_q ^ seed_data;

`ifdef FRV_MASK_RNG_FIFO_EN

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          w_push;

  assign mask_valid = (level_q != '0);
  assign mask_data  = mask_valid ? fifo_q[rd_ptr_q] : '0;
  assign rng_level  = level_q;
  assign w_pop      = mask_valid & mask_ready;
  // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
  assign w_push     = !seed_valid && ((level_q < C_DEPTH) || w_pop);

  always_comb begin
    level_d = level_q;
    lfsr_d  = lfsr_q;
    if (seed_valid) begin
      level_d = '0;
      lfsr_d  = (w_seed_mix == '0) ? SEED : w_seed_mix;
    end else begin
      if (w_push && !w_pop) begin
        level_d = level_q + 1'b1;
      end else if (w_pop && !w_push) begin
        level_d = level_q - 1'b1;
      end
      if (w_push) begin
        lfsr_d = lfsr_step(lfsr_q);
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      lfsr_q   <= SEED;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvfi_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      lfsr_q  <= lfsr_d;
      level_q <= level_d;
      if (w_pop) begin
        rvfi_q <= mask_data;
      end
      if (seed_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (w_push) begin
          fifo_q[wr_ptr_q] <= lfsr_q;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

`else

  logic valid_q;

  assign mask_valid = valid_q;
  assign mask_data  = valid_q ? lfsr_q : '0;
  assign rng_level  = LW'(valid_q);
  assign w_pop      = valid_q & mask_ready;

  // Direct LFSR: one step per consumed word, reseed without a valid gap.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_valid) begin
      lfsr_d = (w_seed_mix == '0) ? SEED : w_seed_mix;
    end else if (w_pop) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      lfsr_q  <= SEED;
      valid_q <= 1'b0;
      rvfi_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b1;
      if (w_pop) begin
        rvfi_q <= mask_data;
      end
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_frv_mask_rng.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_mask_rng
// Purpose  : Directed self-checking bench for frv_mask_rng (SEED=1, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_mask_rng;

  localparam int unsigned DEPTH = 4;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;
  logic        mask_valid;
  logic        mask_ready;
  logic [31:0] mask_data;
  logic [31:0] rvfi_mask_data;
  logic [$clog2(DEPTH):0] rng_level;

  int n_checks = 0;
  int n_fail   = 0;

  // LFSR sequence from SEED=1, worked by hand.
  localparam logic [31:0] S0 = 32'h0000_0001;
  localparam logic [31:0] S1 = 32'h8020_0003;
  localparam logic [31:0] S2 = 32'hC030_0002;
  localparam logic [31:0] S3 = 32'h6018_0001;
  localparam logic [31:0] S7 = 32'hB62D_8003;

  frv_mask_rng #(.DEPTH(DEPTH), .SEED(32'h0000_0001)) dut (
    .g_clk          (g_clk),
    .g_rst          (g_rst),
    .seed_valid     (seed_valid),
    .seed_data      (seed_data),
    .seed_ready     (seed_ready),
    .mask_valid     (mask_valid),
    .mask_ready     (mask_ready),
    .mask_data      (mask_data),
    .rvfi_mask_data (rvfi_mask_data),
    .rng_level      (rng_level)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_valid", {31'd0, mask_valid}, 32'd0);
    chk("rst_data", mask_data, 32'd0);
    chk("rst_rvfi", rvfi_mask_data, 32'd0);
    chk("rst_level", 32'(rng_level), 32'd0);
    chk("rst_seed_ready", {31'd0, seed_ready}, 32'd1);
  endtask

  initial begin
    g_rst      = 1'b1;
    seed_valid = 1'b0;
    seed_data  = '0;
    mask_ready = 1'b1;
    tick(3);
    chk_reset();

    g_rst = 1'b0;
`ifdef FRV_MASK_RNG_FIFO_EN
    chk("empty_valid", {31'd0, mask_valid}, 32'd0);
    tick(1);
    chk("first_valid", {31'd0, mask_valid}, 32'd1);
    chk("empty_ready_no_pop", rvfi_mask_data, 32'd0);
    chk("first_level", 32'(rng_level), 32'd1);
    mask_ready = 1'b0;
    tick(3);
    chk("fill_level", 32'(rng_level), 32'd4);
    tick(2);
    chk("full_hold_level", 32'(rng_level), 32'd4);
    chk("full_head", mask_data, S0);

    mask_ready = 1'b1;
    tick(1);
    chk("pop0_rvfi", rvfi_mask_data, S0);
    chk("pop0_head", mask_data, S1);
    chk("pop0_level", 32'(rng_level), 32'd4);
    tick(1);
    chk("pop1_rvfi", rvfi_mask_data, S1);
    chk("pop1_head", mask_data, S2);
    tick(1);
    chk("pop2_rvfi", rvfi_mask_data, S2);
    chk("pop2_head", mask_data, S3);
    chk("pop2_level", 32'(rng_level), 32'd4);
    mask_ready = 1'b0;

    // Seed equal to the live LFSR state forces a SEED reload.
    seed_valid = 1'b1;
    seed_data  = S7;
    tick(1);
    seed_valid = 1'b0;
    chk("reseed_gap_valid", {31'd0, mask_valid}, 32'd0);
    chk("reseed_gap_level", 32'(rng_level), 32'd0);
    chk("reseed_rvfi_hold", rvfi_mask_data, S2);
    tick(1);
    chk("reseed_valid_back", {31'd0, mask_valid}, 32'd1);
    chk("reseed_head", mask_data, S0);

    // LFSR now S1; reseed with 0xFF while popping head S0.
    seed_valid = 1'b1;
    seed_data  = 32'h0000_00FF;
    mask_ready = 1'b1;
    tick(1);
    seed_valid = 1'b0;
    mask_ready = 1'b0;
    chk("reseed_pop_rvfi", rvfi_mask_data, S0);
    chk("reseed_pop_empty", {31'd0, mask_valid}, 32'd0);
    chk("reseed_pop_level", 32'(rng_level), 32'd0);
    tick(1);
    chk("reseed_pop_head", mask_data, 32'h8020_00FC);
    chk("reseed_pop_valid", {31'd0, mask_valid}, 32'd1);
`else
    chk("nofifo_release_valid", {31'd0, mask_valid}, 32'd0);
    tick(1);
    chk("nofifo_first_valid", {31'd0, mask_valid}, 32'd1);
    chk("nofifo_first_data", mask_data, S0);
    chk("nofifo_no_pop_rvfi", rvfi_mask_data, 32'd0);
    chk("nofifo_level", 32'(rng_level), 32'd1);
    mask_ready = 1'b0;
    tick(2);
    chk("nofifo_hold_data", mask_data, S0);
    mask_ready = 1'b1;
    tick(1);
    chk("nofifo_pop0_data", mask_data, S1);
    chk("nofifo_pop0_rvfi", rvfi_mask_data, S0);
    chk("nofifo_pop0_level", 32'(rng_level), 32'd1);
    tick(1);
    chk("nofifo_pop1_data", mask_data, S2);
    chk("nofifo_pop1_rvfi", rvfi_mask_data, S1);
    mask_ready = 1'b0;

    seed_valid = 1'b1;
    seed_data  = S2;
    tick(1);
    seed_valid = 1'b0;
    chk("nofifo_reseed_zero", mask_data, S0);
    chk("nofifo_reseed_valid", {31'd0, mask_valid}, 32'd1);
    chk("nofifo_reseed_rvfi", rvfi_mask_data, S1);

    seed_valid = 1'b1;
    seed_data  = 32'h0000_00FF;
    mask_ready = 1'b1;
    tick(1);
    seed_valid = 1'b0;
    mask_ready = 1'b0;
    chk("nofifo_reseed_pop_rvfi", rvfi_mask_data, S0);
    chk("nofifo_reseed_pop_data", mask_data, 32'h0000_00FE);
    chk("nofifo_reseed_pop_level", 32'(rng_level), 32'd1);
`endif

    // Reset mid-operation wins over reseed and pop.
    g_rst      = 1'b1;
    seed_valid = 1'b1;
    seed_data  = 32'h1234_5678;
    mask_ready = 1'b1;
    tick(1);
    chk_reset();
    g_rst      = 1'b0;
    seed_valid = 1'b0;
    mask_ready = 1'b0;
    tick(1);
    chk("post_reset_head", mask_data, S0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
